dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer for the shared 16-bit `DataMemory`. It accepts load/store requests from the CPU (port 0) and a secondary master such as DMA or debug (port 1). It serialises them into single-cycle `MemRead`/`MemWrite` accesses and returns a registered acknowledge and read data to the winning port. It sits between the core's memory stage and the `DataMemory` instance and is the only driver of that memory's control, address and write-data inputs.

## Interface
- `ADDR_W`, 16: address width, matching `DataMemory` `addr`.
- `DATA_W`, 16: data width, matching `DataMemory` `write_data`/`read_data`.
- `clk`  in  1  clock; everything is on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `p0_req` / `p1_req`  in  1  access request, level; held until ack.
- `p0_we` / `p1_we`  in  1  1 = write, 0 = read; stable while req is high.
- `p0_addr` / `p1_addr`  in  ADDR_W  word address; stable while req is high.
- `p0_wdata` / `p1_wdata`  in  DATA_W  store data; stable while req is high.
- `p0_ack` / `p1_ack`  out  1  one-cycle completion pulse.
- `p0_rdata` / `p1_rdata`  out  DATA_W  last read result for the port; held.
- `mem_write`  out  1  to `DataMemory.MemWrite`.
- `mem_read`  out  1  to `DataMemory.MemRead`.
- `mem_addr`  out  ADDR_W  to `DataMemory.addr`.
- `mem_wdata`  out  DATA_W  to `DataMemory.write_data`.
- `mem_rdata`  in  DATA_W  from `DataMemory.read_data`; high-Z when `mem_read` = 0.

## Operation
- **FSM states:** IDLE → ACCESS → DONE → IDLE. There are no other states.
- **IDLE:**
  - If any req is high, pick a winner, latch its we/addr/wdata, register `mem_read`/`mem_write` and `mem_addr`/`mem_wdata`, record the grant, and go to ACCESS.
  - If no req is high, stay in IDLE with all `mem_*` = 0.
- **ACCESS:** exactly one of `mem_write`/`mem_read` is 1 for this single cycle.
  - Write: commits in `DataMemory` on the edge that closes ACCESS.
  - Read: `mem_rdata` is captured into the winner's `pN_rdata` on that same edge.
  - `mem_write`/`mem_read` are cleared on that edge.
- **DONE:** the winner's `pN_ack` = 1 for one cycle and all req inputs are ignored. The next state is IDLE.
- **Requester rule:** a requester samples ack at the edge closing DONE and drops or replaces its request so that the new value is visible in the following IDLE cycle. A req still high in IDLE is treated as a new request.
- **Arbitration (default, round-robin):**
  - When both reqs are high in IDLE, the port not granted last wins.
  - The last-grant register resets to 1, so port 0 wins the first tie.
  - A lone request always wins.
- The other port's `pN_rdata` and ack are never disturbed.
- A write does not change either `pN_rdata`.
- `mem_addr`/`mem_wdata` hold their last value outside ACCESS. Their reset value is 0.

## Timing
- **Reset values:** state = IDLE; `mem_write` = `mem_read` = 0; `mem_addr` = `mem_wdata` = 0; `p0_ack` = `p1_ack` = 0; `p0_rdata` = `p1_rdata` = 0; last-grant = 1.
- **Latency:** req first high in IDLE cycle N → ACCESS in cycle N+1 → ack in cycle N+2.
- **Throughput:** one access every 3 cycles. Back-to-back requests alternate ports under contention.
- **Worst-case wait under round-robin:** 3 cycles of the other port's access before a port's own grant cycle.
- **Reset mid-operation:**
  - `rst_n` low sampled at the edge closing ACCESS: a pending write still commits, because the memory sees `MemWrite` high at that edge. No ack is issued and `pN_rdata` is reset instead of loaded.
  - Reset during DONE suppresses the remainder of the ack pulse.
- **Simultaneous events:** a req rising during ACCESS or DONE waits for IDLE. A req falling before ack is a protocol violation; the access completes anyway.

## Configuration
- `DMEM_ARB_FIXED_PRIO_EN` defined: fixed priority, port 0 always wins ties, and the last-grant register is not implemented. Port 1 may starve.
- `DMEM_ARB_FIXED_PRIO_EN` undefined: round-robin as described in Operation.

## Structure
- **Shared package `dmem_pkg`:**
  - FSM state encoding: IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2.
  - Port index constants: `PORT_CPU` = 0, `PORT_AUX` = 1.
  - Default width constants: 16.
- **Sub-module `dmem_rr_pick`:** the combinational 2-way winner select, taking req[1:0] and last-grant and returning a grant index and valid. It contains the `DMEM_ARB_FIXED_PRIO_EN` branch.
- Top-level holds the FSM, latches and `pN_rdata` registers.

## Test plan
- **Reset:** hold `rst_n` = 0 for 2 cycles, then release → all outputs are 0 and `mem_rdata` is Z.
- **Port 0 single write/read:**
  - p0 write 0xABCD to addr 2 → `mem_write` = 1 with `mem_addr` = 2 for exactly one cycle, then `p0_ack` 2 cycles after req.
  - p0 read addr 2 → `p0_rdata` = 0xABCD with `p0_ack`.
- **Port 1 isolation:**
  - p1 write 0x1234 to addr 10, then read addr 10 → `p1_rdata` = 0x1234.
  - `p0_rdata` stays 0xABCD throughout.
- **Simultaneous requests (round-robin):** both ports request continuously after reset → grants go p0, p1, p0, p1, with acks 3 cycles apart. With `DMEM_ARB_FIXED_PRIO_EN` defined → p0 only.
- **Reset during ACCESS:** p0 write 0x5555 to addr 4, with `rst_n` low at the edge closing ACCESS → no `p0_ack`. A subsequent p0 read of addr 4 after reset returns 0x5555.
- **Idle bus:** no requests for 10 cycles → `mem_read` = `mem_write` = 0 every cycle and no acks.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the DataMemory arbiter: FSM encoding, port indices
// and default bus widths.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 16;
  localparam int DMEM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } dmem_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports plus the DataMemory control/data bus.
// slave = arbiter side, master = requesters and memory side.
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
);

  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_ack;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_ack;
  logic [DATA_W-1:0] p1_rdata;

  logic              mem_write;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_ack, p0_rdata, p1_ack, p1_rdata,
    output mem_write, mem_read, mem_addr, mem_wdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_ack, p0_rdata, p1_ack, p1_rdata,
    input  mem_write, mem_read, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dmem_rr_pick.sv
// Combinational two-way winner select. Round-robin on ties by default;
// DMEM_ARB_FIXED_PRIO_EN makes port 0 win every tie and drops last_grant.
module dmem_rr_pick
  import dmem_pkg::*;
(
  input  logic [1:0] req,
`ifndef DMEM_ARB_FIXED_PRIO_EN
  input  logic       last_grant,
`endif
  output logic       grant,
  output logic       valid
);

  // Winner select: a lone request always wins, ties resolved by policy.
  always_comb begin
    valid = |req;
    grant = PORT_CPU;
    case (req)
      2'b01:   grant = PORT_CPU;
      2'b10:   grant = PORT_AUX;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      2'b11:   grant = PORT_CPU;
`else
      2'b11:   grant = ~last_grant;
`endif
      default: grant = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the shared DataMemory: IDLE -> ACCESS -> DONE.
// Optional macro DMEM_ARB_FIXED_PRIO_EN selects fixed priority (port 0).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  dmem_state_e       state;
  logic              grant;
  logic              pick_grant;
  logic              pick_valid;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic              last_grant;
`endif

  dmem_rr_pick u_pick (
    .req        ({bus.p1_req, bus.p0_req}),
`ifndef DMEM_ARB_FIXED_PRIO_EN
    .last_grant (last_grant),
`endif
    .grant      (pick_grant),
    .valid      (pick_valid)
  );

  // Steer the would-be winner's command toward the memory-side registers.
  always_comb begin
    if (pick_grant == PORT_AUX) begin
      sel_we    = bus.p1_we;
      sel_addr  = bus.p1_addr;
      sel_wdata = bus.p1_wdata;
    end else begin
      sel_we    = bus.p0_we;
      sel_addr  = bus.p0_addr;
      sel_wdata = bus.p0_wdata;
    end
  end

`ifndef DMEM_ARB_FIXED_PRIO_EN
  // Remember who was granted last; reset value 1 lets port 0 win the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= PORT_AUX;
    end else if ((state == IDLE) && pick_valid) begin
      last_grant <= pick_grant;
    end else begin
      last_grant <= last_grant;
    end
  end
`endif

  // Sequencer: arbitrate in IDLE, drive one memory cycle, then pulse ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant         <= PORT_CPU;
      bus.mem_write <= 1'b0;
      bus.mem_read  <= 1'b0;
      bus.mem_addr  <= {ADDR_W{1'b0}};
      bus.mem_wdata <= {DATA_W{1'b0}};
      bus.p0_ack    <= 1'b0;
      bus.p1_ack    <= 1'b0;
      bus.p0_rdata  <= {DATA_W{1'b0}};
      bus.p1_rdata  <= {DATA_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          bus.p0_ack <= 1'b0;
          bus.p1_ack <= 1'b0;
          if (pick_valid) begin
            grant         <= pick_grant;
            bus.mem_write <= sel_we;
            bus.mem_read  <= ~sel_we;
            bus.mem_addr  <= sel_addr;
            bus.mem_wdata <= sel_wdata;
            state         <= ACCESS;
          end else begin
            bus.mem_write <= 1'b0;
            bus.mem_read  <= 1'b0;
            state         <= IDLE;
          end
        end
        ACCESS: begin
          // Read data is only valid while mem_read is high, so capture here.
          if (bus.mem_read && (grant == PORT_CPU)) begin
            bus.p0_rdata <= bus.mem_rdata;
          end else if (bus.mem_read && (grant == PORT_AUX)) begin
            bus.p1_rdata <= bus.mem_rdata;
          end else begin
            bus.p0_rdata <= bus.p0_rdata;
          end
          bus.mem_write <= 1'b0;
          bus.mem_read  <= 1'b0;
          bus.p0_ack    <= (grant == PORT_CPU);
          bus.p1_ack    <= (grant == PORT_AUX);
          state         <= DONE;
        end
        DONE: begin
          bus.p0_ack <= 1'b0;
          bus.p1_ack <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          bus.mem_write <= 1'b0;
          bus.mem_read  <= 1'b0;
          bus.p0_ack    <= 1'b0;
          bus.p1_ack    <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised + directed bench for dmem_arbiter against a cycle-scheduled
// behavioural model (grant rule, access at N+1, ack at N+2, next slot at N+3).
module tb_dmem_arbiter;
  import dmem_pkg::*;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
  dmem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // DataMemory stand-in; a junk pattern stands in for the floating bus.
  logic [15:0] dmem [0:255];
  always @(posedge clk) if (bus.mem_write) dmem[bus.mem_addr[7:0]] <= bus.mem_wdata;
  assign bus.mem_rdata = bus.mem_read ? dmem[bus.mem_addr[7:0]] : 16'hDEAD;

  int vectors = 0, miscompares = 0, cyc = 0, rst_cnt = 0;
  int mw_seen = 0, ack_seen = 0;
  req_t q0[$], q1[$];
  bit   active [2];
  req_t cur [2];
  int   present [2];
  bit   random_mode = 1'b0, reset_on_access = 1'b0;

  // Model state
  logic [15:0] ref_mem [0:255];
  int          free_cyc, acc_cyc, acc_port;
  req_t        acc;
  logic [15:0] acc_rdata, last_addr, last_wdata;
  logic [15:0] exp_rd [2];
  logic        last_g;
  int ack_port_log[$], ack_cyc_log[$], ack_lat_log[$];

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    acc_cyc = -100; free_cyc = 0; acc_port = 0;
    last_addr = 16'h0; last_wdata = 16'h0;
    exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
    last_g = 1'b1;
    active[0] = 1'b0; active[1] = 1'b0;
    q0.delete(); q1.delete();
  endtask

  function automatic int qsize(input int p);
    return (p == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push(input int p, input req_t r);
    if (p == 0) q0.push_back(r); else q1.push_back(r);
  endtask

  task automatic pop(input int p, output req_t r);
    if (p == 0) r = q0.pop_front(); else r = q1.pop_front();
  endtask

  task automatic drive_ports();
    bus.p0_req = active[0]; bus.p0_we = cur[0].we;
    bus.p0_addr = cur[0].addr; bus.p0_wdata = cur[0].wdata;
    bus.p1_req = active[1]; bus.p1_we = cur[1].we;
    bus.p1_addr = cur[1].addr; bus.p1_wdata = cur[1].wdata;
  endtask

  task automatic step();
    bit   e_acc, e_ack;
    logic w;
    @(negedge clk);
    e_acc = (cyc == acc_cyc);
    e_ack = (cyc == acc_cyc + 1);
    if (e_acc) begin last_addr = acc.addr; last_wdata = acc.wdata; end
    if (e_ack && !acc.we) exp_rd[acc_port] = acc_rdata;
    cmp("mem_write", 16'(bus.mem_write), 16'(e_acc && acc.we));
    cmp("mem_read",  16'(bus.mem_read),  16'(e_acc && !acc.we));
    cmp("mem_addr",  bus.mem_addr,  last_addr);
    cmp("mem_wdata", bus.mem_wdata, last_wdata);
    cmp("p0_ack",    16'(bus.p0_ack), 16'(e_ack && acc_port == 0));
    cmp("p1_ack",    16'(bus.p1_ack), 16'(e_ack && acc_port == 1));
    cmp("p0_rdata",  bus.p0_rdata, exp_rd[0]);
    cmp("p1_rdata",  bus.p1_rdata, exp_rd[1]);
    if (bus.mem_write) mw_seen++;
    if (bus.p0_ack || bus.p1_ack) ack_seen++;

    if (reset_on_access && e_acc) begin rst_cnt = 2; reset_on_access = 1'b0; end
    if (rst_cnt > 0) begin
      if (rst_n) model_reset();
      rst_n = 1'b0;
      rst_cnt--;
    end else begin
      rst_n = 1'b1;
    end

    for (int p = 0; p < 2; p++) begin
      logic ackp;
      req_t r;
      ackp = (p == 0) ? bus.p0_ack : bus.p1_ack;
      if (ackp && active[p]) begin
        ack_port_log.push_back(p);
        ack_cyc_log.push_back(cyc);
        ack_lat_log.push_back(cyc - present[p]);
        active[p] = 1'b0;
      end
      if (random_mode && rst_n && qsize(p) == 0 && $urandom_range(0, 3) == 0) begin
        r.we = 1'($urandom_range(0, 1));
        r.addr = 16'($urandom_range(0, 15));
        r.wdata = 16'($urandom);
        push(p, r);
      end
      if (!active[p] && rst_n && qsize(p) != 0) begin
        pop(p, r);
        cur[p] = r;
        active[p] = 1'b1;
        present[p] = cyc;
      end
    end
    drive_ports();

    // Model: an idle slot with a pending request starts an access next cycle.
    if (rst_n && cyc >= free_cyc && (active[0] || active[1])) begin
      if (active[0] && active[1]) w = FIXED ? 1'b0 : ~last_g;
      else w = active[1];
      acc = cur[w]; acc_port = int'(w); acc_cyc = cyc + 1; free_cyc = cyc + 3; last_g = w;
      if (acc.we) ref_mem[acc.addr[7:0]] = acc.wdata;
      else acc_rdata = ref_mem[acc.addr[7:0]];
    end
    cyc++;
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    while ((active[0] || active[1] || q0.size() != 0 || q1.size() != 0) && n < maxc) begin
      step();
      n++;
    end
    if (active[0] || active[1] || q0.size() != 0 || q1.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout cycle %0d: requests still pending after %0d cycles", cyc, maxc);
    end
    repeat (3) step();
  endtask

  initial begin
    int base, mw0, ak0;
    for (int i = 0; i < 256; i++) begin dmem[i] = 16'h0; ref_mem[i] = 16'h0; end
    cur[0] = '0; cur[1] = '0;
    model_reset();
    drive_ports();
    rst_cnt = 2;
    repeat (4) step();
    cmp("rst_mem_addr", bus.mem_addr, 16'h0000);
    cmp("rst_p0_rdata", bus.p0_rdata, 16'h0000);

    // Port 0 write then read
    base = ack_port_log.size(); mw0 = mw_seen;
    push(0, {1'b1, 16'd2, 16'hABCD});
    wait_done(20);
    cmp("p0_wr_port", 16'(ack_port_log[base]), 16'd0);
    cmp("p0_wr_latency", 16'(ack_lat_log[base]), 16'd2);
    cmp("p0_wr_pulse", 16'(mw_seen - mw0), 16'd1);
    base = ack_port_log.size();
    push(0, {1'b0, 16'd2, 16'h0000});
    wait_done(20);
    cmp("p0_rd_data", bus.p0_rdata, 16'hABCD);
    cmp("p0_rd_latency", 16'(ack_lat_log[base]), 16'd2);

    // Port 1 isolation
    push(1, {1'b1, 16'd10, 16'h1234});
    push(1, {1'b0, 16'd10, 16'h0000});
    wait_done(30);
    cmp("p1_rd_data", bus.p1_rdata, 16'h1234);
    cmp("p0_rd_kept", bus.p0_rdata, 16'hABCD);

    // Idle bus
    mw0 = mw_seen; ak0 = ack_seen;
    repeat (10) step();
    cmp("idle_writes", 16'(mw_seen - mw0), 16'd0);
    cmp("idle_acks", 16'(ack_seen - ak0), 16'd0);

    // Reset while a write is in its ACCESS cycle
    ak0 = ack_seen;
    push(0, {1'b1, 16'd4, 16'h5555});
    reset_on_access = 1'b1;
    wait_done(20);
    repeat (2) step();
    cmp("rst_acc_no_ack", 16'(ack_seen - ak0), 16'd0);
    push(0, {1'b0, 16'd4, 16'h0000});
    wait_done(20);
    cmp("rst_acc_commit", bus.p0_rdata, 16'h5555);

    // Contention straight after reset
    rst_cnt = 2;
    repeat (4) step();
    base = ack_port_log.size();
    for (int i = 0; i < 4; i++) begin
      push(0, {1'b0, 16'(i), 16'h0000});
      push(1, {1'b0, 16'(i + 20), 16'h0000});
    end
    wait_done(100);
    for (int i = 0; i < 4; i++) begin
      cmp("tie_order", 16'(ack_port_log[base + i]), FIXED ? 16'd0 : 16'(i % 2));
      if (i > 0) cmp("tie_spacing", 16'(ack_cyc_log[base + i] - ack_cyc_log[base + i - 1]), 16'd3);
    end

    // Random traffic
    random_mode = 1'b1;
    repeat (3000) step();
    random_mode = 1'b0;
    wait_done(300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
